// File: rtl/seq_det_pkg.sv
// Shared constants and config record for the serial pattern detector family.
package seq_det_pkg;

  localparam int               SEQ_MAX_LEN     = 8;
  localparam logic [7:0]       SEQ_DEF_PATTERN = 8'b0001_0011;
  localparam int               SEQ_DEF_LEN     = 5;
  localparam logic             SEQ_DEF_OVERLAP = 1'b1;

  // One channel's runtime configuration, sized for the default MAX_LEN.
  typedef struct packed {
    logic [SEQ_MAX_LEN-1:0]             pattern;
    logic [$clog2(SEQ_MAX_LEN+1)-1:0]   len;
    logic                               overlap;
  } seq_cfg_t;

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // Count up until all ones, then hold; clr forces zero.
  always_ff @(posedge clk) begin
    if (rst || clr)               cnt <= '0;
    else if (inc && (cnt != '1))  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable Moore serial pattern detector with match counter.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = SEQ_MAX_LEN,
  parameter int                 LEN_W       = $clog2(MAX_LEN+1),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQ_DEF_PATTERN),
  parameter int                 DEF_LEN     = SEQ_DEF_LEN,
  parameter logic               DEF_OVERLAP = SEQ_DEF_OVERLAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   active_len
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_r, hist, hist_next, mask;
  logic [LEN_W-1:0]   len_r, fill, fill_next, len_clamp;
  logic               ovl_r, match;

  // Post-shift history view; match is judged on what the history will become.
  always_comb begin
    hist_next = {hist[MAX_LEN-2:0], in};
    fill_next = (fill == MAX_L) ? fill : fill + 1'b1;
    len_clamp = (cfg_len > MAX_L) ? MAX_L : cfg_len;
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len_r);
    match     = en && !cfg_load && (len_r != '0) && (fill_next >= len_r) &&
                (((hist_next ^ pattern_r) & mask) == '0);
  end

  // Config, history and registered match pulse; cfg_load outranks sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_r <= DEF_PATTERN;
      len_r     <= LEN_W'(DEF_LEN);
      ovl_r     <= DEF_OVERLAP;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
    end else if (cfg_load) begin
      pattern_r <= cfg_pattern;
      len_r     <= len_clamp;
      ovl_r     <= cfg_overlap;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
    end else if (en) begin
      if (match && !ovl_r) begin
        // Non-overlapping: the next match must be built from fresh bits.
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= hist_next;
        fill <= fill_next;
      end
      out <= match;
    end else begin
      out <= 1'b0;
    end
  end

  assign active_len = len_r;

  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

endmodule
